// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: PID codes, link-control states and
// small PID classification helpers.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        LC_IDLE,
        LC_TOK_CHK,
        LC_RX_DATA,
        LC_WAIT_RESP,
        LC_TX_HS,
        LC_TX_DATA,
        LC_WAIT_HS
    } link_state_e;

    function automatic logic is_token(logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP);
    endfunction

    // States that wait on the bus or the transfer layer and must time out.
    function automatic logic is_wait_state(link_state_e s);
        return (s == LC_RX_DATA) || (s == LC_WAIT_RESP) || (s == LC_TX_HS) ||
               (s == LC_TX_DATA) || (s == LC_WAIT_HS);
    endfunction

endpackage

// File: rtl/usb_link_ctrl_if.sv
// Signal bundle between the link controller, usb_link_rx, the handshake
// transmitter and the transfer layer.
interface usb_link_ctrl_if;

    logic       rx_pid_en;
    logic [3:0] rx_pid;
    logic       crc5_err;
    logic       rx_lt_eop;
    logic       crc16_err;
    logic       tl_resp_valid;
    logic [3:0] tl_resp_pid;
    logic       tl_data_done;
    logic       tx_done;

    logic       rx_handshake_on;
    logic       tx_hs_start;
    logic [3:0] tx_pid;
    logic       tl_data_start;
    logic       tl_setup;
    logic       sof_pulse;
    logic       trans_ok;
    logic       trans_err;
    logic       timeout;

    modport slave (
        input  rx_pid_en, rx_pid, crc5_err, rx_lt_eop, crc16_err,
               tl_resp_valid, tl_resp_pid, tl_data_done, tx_done,
        output rx_handshake_on, tx_hs_start, tx_pid, tl_data_start, tl_setup,
               sof_pulse, trans_ok, trans_err, timeout
    );

    modport master (
        output rx_pid_en, rx_pid, crc5_err, rx_lt_eop, crc16_err,
               tl_resp_valid, tl_resp_pid, tl_data_done, tx_done,
        input  rx_handshake_on, tx_hs_start, tx_pid, tl_data_start, tl_setup,
               sof_pulse, trans_ok, trans_err, timeout
    );

endinterface

// File: rtl/usb_turnaround_timer.sv
// Bus-turnaround timer: counts enabled cycles and flags the terminal count
// so a waiting state can give up after TO_CYCLES cycles.
module usb_turnaround_timer #(
    parameter int unsigned      CNT_W     = 16,
    parameter logic [CNT_W-1:0] TO_CYCLES = 16'd600
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = TO_CYCLES - CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset branch is synchronous (inside the clocked block).
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/usb_link_ctrl.sv
// Device-side USB link-layer transaction sequencer: token decode, data and
// handshake sequencing, and turnaround timeouts back to idle.
module usb_link_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned      CNT_W     = 16,
    parameter logic [CNT_W-1:0] TO_CYCLES = 16'd600
) (
    input  logic          clk,
    input  logic          rst,
    usb_link_ctrl_if.slave bus
);

    link_state_e state_q, state_d;
    logic [3:0]  tok_pid_q, tok_pid_d;
    logic        tok_late_q, tok_late_d;
    logic [3:0]  tx_pid_q, tx_pid_d;
    logic        tl_setup_q, tl_setup_d;
    logic        rx_handshake_on_q, rx_handshake_on_d;
    logic        tx_hs_start_q, tx_hs_start_d;
    logic        tl_data_start_q, tl_data_start_d;
    logic        sof_pulse_q, sof_pulse_d;
    logic        trans_ok_q, trans_ok_d;
    logic        trans_err_q, trans_err_d;
    logic        timeout_q, timeout_d;

    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    assign timer_clr = (state_d != state_q);
    assign timer_en  = is_wait_state(state_q);

    usb_turnaround_timer #(
        .CNT_W    (CNT_W),
        .TO_CYCLES(TO_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(timer_expired)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d         = state_q;
        tok_pid_d       = tok_pid_q;
        tok_late_d      = 1'b0;
        tx_pid_d        = tx_pid_q;
        tl_setup_d      = tl_setup_q;
        tx_hs_start_d   = 1'b0;
        tl_data_start_d = 1'b0;
        sof_pulse_d     = 1'b0;
        trans_ok_d      = 1'b0;
        trans_err_d     = 1'b0;
        timeout_d       = 1'b0;

        case (state_q)
            LC_IDLE: begin
                if (bus.rx_pid_en) begin
                    if (is_token(bus.rx_pid)) begin
                        tok_pid_d  = bus.rx_pid;
                        tl_setup_d = (bus.rx_pid == PID_SETUP);
                        state_d    = LC_TOK_CHK;
                    end else if (bus.rx_pid == PID_SOF) begin
                        sof_pulse_d = 1'b1;
                    end
                end
            end
            // Two cycles here let the late CRC5 verdict of the token arrive.
            LC_TOK_CHK: begin
                if (bus.crc5_err) begin
                    state_d = LC_IDLE;
                end else if (!tok_late_q) begin
                    tok_late_d = 1'b1;
                end else if (tok_pid_q == PID_IN) begin
                    tl_data_start_d = 1'b1;
                    state_d         = LC_TX_DATA;
                end else begin
                    state_d = LC_RX_DATA;
                end
            end
            LC_RX_DATA: begin
                if (bus.rx_lt_eop) begin
                    if (bus.crc16_err) begin
                        trans_err_d = 1'b1;
                        state_d     = LC_IDLE;
                    end else begin
                        state_d = LC_WAIT_RESP;
                    end
                end
            end
            LC_WAIT_RESP: begin
                if (bus.tl_resp_valid) begin
                    tx_pid_d      = bus.tl_resp_pid;
                    tx_hs_start_d = 1'b1;
                    state_d       = LC_TX_HS;
                end
            end
            LC_TX_HS: begin
                if (bus.tx_done) begin
                    trans_ok_d  = (tx_pid_q == PID_ACK);
                    trans_err_d = (tx_pid_q != PID_ACK);
                    state_d     = LC_IDLE;
                end
            end
            LC_TX_DATA: begin
                if (bus.tl_data_done) begin
                    state_d = LC_WAIT_HS;
                end
            end
            LC_WAIT_HS: begin
                if (bus.rx_pid_en) begin
                    trans_ok_d  = (bus.rx_pid == PID_ACK);
                    trans_err_d = (bus.rx_pid != PID_ACK);
                    state_d     = LC_IDLE;
                end
            end
            default: state_d = LC_IDLE;
        endcase

        // Every exit event changes state, so an unchanged state means the exit
        // event was absent and the terminal count may fire.
        if (timer_expired && (state_d == state_q)) begin
            timeout_d = 1'b1;
            state_d   = LC_IDLE;
        end

        if (state_d == LC_IDLE) begin
            tl_setup_d = 1'b0;
        end
        rx_handshake_on_d = (state_d == LC_WAIT_HS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= LC_IDLE;
            tok_pid_q         <= 4'b0000;
            tok_late_q        <= 1'b0;
            tx_pid_q          <= 4'b0000;
            tl_setup_q        <= 1'b0;
            rx_handshake_on_q <= 1'b0;
            tx_hs_start_q     <= 1'b0;
            tl_data_start_q   <= 1'b0;
            sof_pulse_q       <= 1'b0;
            trans_ok_q        <= 1'b0;
            trans_err_q       <= 1'b0;
            timeout_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            tok_pid_q         <= tok_pid_d;
            tok_late_q        <= tok_late_d;
            tx_pid_q          <= tx_pid_d;
            tl_setup_q        <= tl_setup_d;
            rx_handshake_on_q <= rx_handshake_on_d;
            tx_hs_start_q     <= tx_hs_start_d;
            tl_data_start_q   <= tl_data_start_d;
            sof_pulse_q       <= sof_pulse_d;
            trans_ok_q        <= trans_ok_d;
            trans_err_q       <= trans_err_d;
            timeout_q         <= timeout_d;
        end
    end

    assign bus.rx_handshake_on = rx_handshake_on_q;
    assign bus.tx_hs_start     = tx_hs_start_q;
    assign bus.tx_pid          = tx_pid_q;
    assign bus.tl_data_start   = tl_data_start_q;
    assign bus.tl_setup        = tl_setup_q;
    assign bus.sof_pulse       = sof_pulse_q;
    assign bus.trans_ok        = trans_ok_q;
    assign bus.trans_err       = trans_err_q;
    assign bus.timeout         = timeout_q;

endmodule

// File: tb/tb_usb_link_ctrl.sv
// Self-checking bench for usb_link_ctrl: directed vector table, hand-written
// timeout/reset sequences and random transactions against a transaction model.
module tb_usb_link_ctrl;
    import usb_pkg::*;

    localparam int TO = 8;

    typedef struct packed {
        logic       pid_en;
        logic [3:0] pid;
        logic       crc5;
        logic       eop;
        logic       crc16;
        logic       resp_valid;
        logic [3:0] resp_pid;
        logic       data_done;
        logic       tx_done;
    } stim_t;

    typedef struct packed {
        logic       hs_on;
        logic       hs_start;
        logic [3:0] tx_pid;
        logic       data_start;
        logic       setup;
        logic       sof;
        logic       ok;
        logic       err;
        logic       tmo;
    } out_t;

    typedef struct {
        string name;
        stim_t in;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    vec_t  tbl[$];
    stim_t sq[$];
    out_t  eq[$];
    out_t  lv;   // level outputs the model expects between events

    usb_link_ctrl_if bus();

    usb_link_ctrl #(
        .CNT_W    (16),
        .TO_CYCLES(16'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus / expectation helpers ----------------
    function automatic stim_t idl();
        return '0;
    endfunction
    function automatic stim_t tok(logic [3:0] p);
        stim_t s = '0;
        s.pid_en = 1'b1;
        s.pid    = p;
        return s;
    endfunction
    function automatic stim_t c5();
        stim_t s = '0;
        s.crc5 = 1'b1;
        return s;
    endfunction
    function automatic stim_t eop(logic bad);
        stim_t s = '0;
        s.eop   = 1'b1;
        s.crc16 = bad;
        return s;
    endfunction
    function automatic stim_t resp(logic [3:0] p);
        stim_t s = '0;
        s.resp_valid = 1'b1;
        s.resp_pid   = p;
        return s;
    endfunction
    function automatic stim_t ddone();
        stim_t s = '0;
        s.data_done = 1'b1;
        return s;
    endfunction
    function automatic stim_t txdone();
        stim_t s = '0;
        s.tx_done = 1'b1;
        return s;
    endfunction

    function automatic out_t o(logic hs_on, logic hs_start, logic [3:0] txp, logic ds,
                               logic setup, logic sof, logic ok, logic err, logic tmo);
        out_t r;
        r = '{hs_on, hs_start, txp, ds, setup, sof, ok, err, tmo};
        return r;
    endfunction

    task automatic drive(input stim_t s);
        bus.rx_pid_en     = s.pid_en;
        bus.rx_pid        = s.pid;
        bus.crc5_err      = s.crc5;
        bus.rx_lt_eop     = s.eop;
        bus.crc16_err     = s.crc16;
        bus.tl_resp_valid = s.resp_valid;
        bus.tl_resp_pid   = s.resp_pid;
        bus.tl_data_done  = s.data_done;
        bus.tx_done       = s.tx_done;
    endtask

    function automatic out_t sample();
        out_t r;
        r.hs_on      = bus.rx_handshake_on;
        r.hs_start   = bus.tx_hs_start;
        r.tx_pid     = bus.tx_pid;
        r.data_start = bus.tl_data_start;
        r.setup      = bus.tl_setup;
        r.sof        = bus.sof_pulse;
        r.ok         = bus.trans_ok;
        r.err        = bus.trans_err;
        r.tmo        = bus.timeout;
        return r;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: {hs_on,hs_start,tx_pid,data_start,setup,sof,ok,err,timeout} got %b expected %b",
                     name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample the registered response 1 ns after the edge.
    task automatic step(input stim_t s, input out_t e, input string name);
        drive(s);
        @(posedge clk);
        #1;
        check(name, sample(), e);
    endtask

    task automatic add(input string n, input stim_t s, input out_t e);
        vec_t v;
        v.name = n;
        v.in   = s;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic out_t quiet(out_t e);
        out_t r = e;
        r.hs_start = 1'b0; r.data_start = 1'b0; r.sof = 1'b0;
        r.ok = 1'b0; r.err = 1'b0; r.tmo = 1'b0;
        return r;
    endfunction

    // Random pulses on every input except the one the current phase waits for.
    function automatic stim_t noise(int kind);
        stim_t s = '0;
        s.pid_en     = ($urandom_range(0, 3) == 0);
        s.pid        = 4'($urandom);
        s.crc5       = ($urandom_range(0, 3) == 0);
        s.eop        = ($urandom_range(0, 3) == 0);
        s.crc16      = 1'($urandom_range(0, 1));
        s.resp_valid = ($urandom_range(0, 3) == 0);
        s.resp_pid   = 4'($urandom);
        s.data_done  = ($urandom_range(0, 3) == 0);
        s.tx_done    = ($urandom_range(0, 3) == 0);
        case (kind)
            0: if (s.pid inside {PID_OUT, PID_IN, PID_SETUP, PID_SOF}) s.pid_en = 1'b0;
            1: s.eop        = 1'b0;
            2: s.resp_valid = 1'b0;
            3: s.tx_done    = 1'b0;
            4: s.data_done  = 1'b0;
            default: s.pid_en = 1'b0;
        endcase
        return s;
    endfunction

    task automatic push(input stim_t s, input out_t e);
        sq.push_back(s);
        eq.push_back(e);
    endtask

    // The awaited event arrives after d quiet cycles; if d reaches the timeout
    // budget, the TO-th cycle in the phase reports a timeout instead.
    task automatic wait_phase(input int kind, input stim_t ev, input out_t ev_out,
                              output bit timed_out);
        int   d;
        out_t e;
        d = $urandom_range(0, TO + 1);
        timed_out = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (k == d) begin
                push(ev, ev_out);
                lv = quiet(ev_out);
                return;
            end
            if (k == TO - 1) begin
                e = lv;
                e.tmo = 1'b1; e.setup = 1'b0; e.hs_on = 1'b0;
                push(noise(kind), e);
                lv = quiet(e);
                timed_out = 1'b1;
                return;
            end
            push(noise(kind), lv);
        end
    endtask

    function automatic logic [3:0] pick_hs();
        case ($urandom_range(0, 3))
            0: return PID_ACK;
            1: return PID_NAK;
            2: return PID_STALL;
            default: return 4'($urandom);
        endcase
    endfunction

    task automatic gen_txn();
        logic [3:0] t;
        logic [3:0] p;
        int         c;
        bit         tmo;
        bit         bad;
        out_t       e;
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
            if ($urandom_range(0, 5) == 0) begin
                e = lv; e.sof = 1'b1;
                push(tok(PID_SOF), e);
            end else begin
                push(noise(0), lv);
            end
        end
        case ($urandom_range(0, 2))
            0: t = PID_OUT;
            1: t = PID_SETUP;
            default: t = PID_IN;
        endcase
        lv.setup = (t == PID_SETUP);
        push(tok(t), lv);
        c = $urandom_range(0, 5);
        if (c == 1) begin lv.setup = 1'b0; push(c5(), lv); return; end
        push(idl(), lv);
        if (c == 2) begin lv.setup = 1'b0; push(c5(), lv); return; end
        e = lv; e.data_start = (t == PID_IN);
        push(idl(), e);
        if (t == PID_IN) begin
            e = lv; e.hs_on = 1'b1;
            wait_phase(4, ddone(), e, tmo);
            if (tmo) return;
            p = pick_hs();
            e = lv; e.hs_on = 1'b0; e.ok = (p == PID_ACK); e.err = (p != PID_ACK);
            wait_phase(5, tok(p), e, tmo);
        end else begin
            bad = ($urandom_range(0, 3) == 0);
            e = lv; e.err = bad; if (bad) e.setup = 1'b0;
            wait_phase(1, eop(bad), e, tmo);
            if (tmo || bad) return;
            p = pick_hs();
            e = lv; e.hs_start = 1'b1; e.tx_pid = p;
            wait_phase(2, resp(p), e, tmo);
            if (tmo) return;
            e = lv; e.ok = (p == PID_ACK); e.err = (p != PID_ACK); e.setup = 1'b0;
            wait_phase(3, txdone(), e, tmo);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] tp;
        drive(idl());
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", sample(), '0);
        rst = 1'b1;

        // Directed table: each row is one cycle, starting from IDLE.
        tp = PID_ACK;
        add("out_tok",      tok(PID_OUT),   o(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        add("out_chk1",     idl(),          o(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        add("out_chk2",     idl(),          o(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        add("out_eop_good", eop(1'b0),      o(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
        add("out_resp_ack", resp(PID_ACK),  o(0, 1, tp,   0, 0, 0, 0, 0, 0));
        add("out_hs_wait",  idl(),          o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("out_tx_done",  txdone(),       o(0, 0, tp,   0, 0, 0, 1, 0, 0));
        add("out_idle",     idl(),          o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("bad_tok",      tok(PID_OUT),   o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("bad_chk1",     idl(),          o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("bad_chk2",     idl(),          o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("bad_eop_crc",  eop(1'b1),      o(0, 0, tp,   0, 0, 0, 0, 1, 0));
        add("bad_no_hs",    resp(PID_ACK),  o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("in_tok",       tok(PID_IN),    o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("in_chk1",      idl(),          o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("in_data_start",idl(),          o(0, 0, tp,   1, 0, 0, 0, 0, 0));
        add("in_tx_data",   idl(),          o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("in_data_done", ddone(),        o(1, 0, tp,   0, 0, 0, 0, 0, 0));
        add("in_wait_hs",   idl(),          o(1, 0, tp,   0, 0, 0, 0, 0, 0));
        add("in_host_nak",  tok(PID_NAK),   o(0, 0, tp,   0, 0, 0, 0, 1, 0));
        add("crc5_tok",     tok(PID_SETUP), o(0, 0, tp,   0, 1, 0, 0, 0, 0));
        add("crc5_err",     c5(),           o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("crc5_stray_eop", eop(1'b1),    o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("crc5_stray_rsp", resp(PID_ACK),o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("sof",          tok(PID_SOF),   o(0, 0, tp,   0, 0, 1, 0, 0, 0));
        add("sof_after",    idl(),          o(0, 0, tp,   0, 0, 0, 0, 0, 0));
        add("setup_tok",    tok(PID_SETUP), o(0, 0, tp,   0, 1, 0, 0, 0, 0));
        add("setup_chk1",   idl(),          o(0, 0, tp,   0, 1, 0, 0, 0, 0));
        add("setup_chk2",   tok(PID_OUT),   o(0, 0, tp,   0, 1, 0, 0, 0, 0));
        add("setup_eop",    eop(1'b0),      o(0, 0, tp,   0, 1, 0, 0, 0, 0));
        add("setup_stall",  resp(PID_STALL),o(0, 1, PID_STALL, 0, 1, 0, 0, 0, 0));
        add("setup_txdone", txdone(),       o(0, 0, PID_STALL, 0, 0, 0, 0, 1, 0));
        foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].name);

        // WAIT_HS timeout: fires on the 8th cycle after entry.
        tp = PID_STALL;
        step(tok(PID_IN), o(0, 0, tp, 0, 0, 0, 0, 0, 0), "to_tok");
        step(idl(),       o(0, 0, tp, 0, 0, 0, 0, 0, 0), "to_chk1");
        step(idl(),       o(0, 0, tp, 1, 0, 0, 0, 0, 0), "to_start");
        step(ddone(),     o(1, 0, tp, 0, 0, 0, 0, 0, 0), "to_enter");
        for (int k = 0; k < TO - 1; k++) step(idl(), o(1, 0, tp, 0, 0, 0, 0, 0, 0), "to_waiting");
        step(idl(),       o(0, 0, tp, 0, 0, 0, 0, 0, 1), "to_expire");
        step(idl(),       o(0, 0, tp, 0, 0, 0, 0, 0, 0), "to_after");

        // Same again with the ACK on the terminal cycle: the handshake wins.
        step(tok(PID_IN), o(0, 0, tp, 0, 0, 0, 0, 0, 0), "tie_tok");
        step(idl(),       o(0, 0, tp, 0, 0, 0, 0, 0, 0), "tie_chk1");
        step(idl(),       o(0, 0, tp, 1, 0, 0, 0, 0, 0), "tie_start");
        step(ddone(),     o(1, 0, tp, 0, 0, 0, 0, 0, 0), "tie_enter");
        for (int k = 0; k < TO - 1; k++) step(idl(), o(1, 0, tp, 0, 0, 0, 0, 0, 0), "tie_waiting");
        step(tok(PID_ACK),o(0, 0, tp, 0, 0, 0, 1, 0, 0), "tie_ack");
        step(idl(),       o(0, 0, tp, 0, 0, 0, 0, 0, 0), "tie_after");

        // Reset in the middle of TX_DATA, then SOF from a clean IDLE.
        step(tok(PID_IN), o(0, 0, tp, 0, 0, 0, 0, 0, 0), "rst_tok");
        step(idl(),       o(0, 0, tp, 0, 0, 0, 0, 0, 0), "rst_chk1");
        step(idl(),       o(0, 0, tp, 1, 0, 0, 0, 0, 0), "rst_start");
        step(idl(),       o(0, 0, tp, 0, 0, 0, 0, 0, 0), "rst_tx_data");
        rst = 1'b0;
        step(ddone(),     o(0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "rst_applied");
        rst = 1'b1;
        step(ddone(),     o(0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "rst_idle");
        step(tok(PID_SOF),o(0, 0, 4'h0, 0, 0, 1, 0, 0, 0), "rst_sof");
        step(tok(PID_ACK),o(0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "rst_stray_ack");

        // Random transactions against the transaction-level model.
        lv = '0;
        for (int t = 0; t < 150; t++) gen_txn();
        foreach (sq[i]) step(sq[i], eq[i], $sformatf("rand_cycle_%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
